// File: rtl/cnn_pkg.sv
// Shared CNN front-end types: pixel width, default image size and the pixel typedef
// used by both the window generator and the downstream MAC.
package cnn_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned IMG_W_DEF = 28;
    localparam int unsigned IMG_H_DEF = 28;

    typedef logic [PIX_W-1:0] pixel_t;

    // One window column; index 0 is the oldest line, index 2 the current line.
    typedef pixel_t [2:0] column_t;

    // Stride-2 keep test: (r-2) and (c-2) are even exactly when r and c are even.
    function automatic logic stride2_keep(input logic row_lsb, input logic col_lsb);
        return ~row_lsb & ~col_lsb;
    endfunction

endpackage

// File: rtl/line_delay.sv
// Enable-gated line delay: returns the pixel written DEPTH accepted pixels ago, using a
// circular buffer with a single shared read/write pointer (read-before-write).
module line_delay
    import cnn_pkg::*;
#(
    parameter int unsigned DEPTH = IMG_W_DEF
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   en_i,
    input  pixel_t din_i,
    output pixel_t dout_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pixel_t          mem_q [DEPTH];
    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;

    assign dout_o = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == PtrW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Contents are never cleared; stale data is masked by the row gating upstream.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator (no padding). Define WINDOW_STRIDE2_EN to emit
// only windows whose top-left corner sits on even row and column (stride 2).
module window_gen_3x3
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  pixel_t pix_in,
    input  logic   pix_in_valid,
    input  logic   sof,
    output pixel_t w00,
    output pixel_t w01,
    output pixel_t w02,
    output pixel_t w10,
    output pixel_t w11,
    output pixel_t w12,
    output pixel_t w20,
    output pixel_t w21,
    output pixel_t w22,
    output logic   window_valid,
    output logic   frame_done
);

    localparam int unsigned ColW = $clog2(IMG_W);
    localparam int unsigned RowW = $clog2(IMG_H);

    logic [ColW-1:0] col_q, col_d, cur_col;
    logic [RowW-1:0] row_q, row_d, cur_row;
    logic            last_col, last_row, emit;
    logic            window_valid_q, window_valid_d;
    logic            frame_done_q, frame_done_d;
    pixel_t          line1, line2;
    column_t [2:0]   win_q, win_d;

    line_delay #(
        .DEPTH (IMG_W)
    ) u_line_delay_1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (pix_in_valid),
        .din_i  (pix_in),
        .dout_o (line1)
    );

    line_delay #(
        .DEPTH (IMG_W)
    ) u_line_delay_2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (pix_in_valid),
        .din_i  (line1),
        .dout_o (line2)
    );

    // Position of the pixel on the input this cycle; sof forces it to (0,0).
    always_comb begin
        cur_col  = sof ? '0 : col_q;
        cur_row  = sof ? '0 : row_q;
        last_col = (cur_col == ColW'(IMG_W - 1));
        last_row = (cur_row == RowW'(IMG_H - 1));
`ifdef WINDOW_STRIDE2_EN
        emit = (cur_row >= RowW'(2)) && (cur_col >= ColW'(2)) &&
               stride2_keep(cur_row[0], cur_col[0]);
`else
        emit = (cur_row >= RowW'(2)) && (cur_col >= ColW'(2));
`endif
    end

    always_comb begin
        col_d          = col_q;
        row_d          = row_q;
        win_d          = win_q;
        window_valid_d = 1'b0;
        frame_done_d   = 1'b0;
        if (pix_in_valid) begin
            col_d          = last_col ? '0 : cur_col + 1'b1;
            row_d          = last_col ? (last_row ? '0 : cur_row + 1'b1) : cur_row;
            win_d[0]       = win_q[1];
            win_d[1]       = win_q[2];
            win_d[2]       = {pix_in, line1, line2};
            window_valid_d = emit;
            frame_done_d   = last_col && last_row;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q          <= '0;
            row_q          <= '0;
            win_q          <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            win_q          <= win_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // win_q is indexed [column][row].
    assign w00          = win_q[0][0];
    assign w01          = win_q[1][0];
    assign w02          = win_q[2][0];
    assign w10          = win_q[0][1];
    assign w11          = win_q[1][1];
    assign w12          = win_q[2][1];
    assign w20          = win_q[0][2];
    assign w21          = win_q[1][2];
    assign w22          = win_q[2][2];
    assign window_valid = window_valid_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3: three instances (4x4, 5x5, 6x6) share the input
// stream, only the selected one sees valid; expected pulses go through a stamped scoreboard.
module tb_window_gen_3x3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pix = '0;
    logic       valid = 1'b0;
    logic       sofi = 1'b0;
    int         sel = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic va, vb, vc;
    assign va = valid && (sel == 0);
    assign vb = valid && (sel == 1);
    assign vc = valid && (sel == 2);

    logic [8:0][7:0] wa, wb, wc, s_w;
    logic wva, wvb, wvc, fda, fdb, fdc, s_wv, s_fd, other_pulse;

    window_gen_3x3 #(.IMG_W(4), .IMG_H(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_in(pix), .pix_in_valid(va), .sof(sofi),
        .w00(wa[0]), .w01(wa[1]), .w02(wa[2]), .w10(wa[3]), .w11(wa[4]), .w12(wa[5]),
        .w20(wa[6]), .w21(wa[7]), .w22(wa[8]), .window_valid(wva), .frame_done(fda));

    window_gen_3x3 #(.IMG_W(5), .IMG_H(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_in(pix), .pix_in_valid(vb), .sof(sofi),
        .w00(wb[0]), .w01(wb[1]), .w02(wb[2]), .w10(wb[3]), .w11(wb[4]), .w12(wb[5]),
        .w20(wb[6]), .w21(wb[7]), .w22(wb[8]), .window_valid(wvb), .frame_done(fdb));

    window_gen_3x3 #(.IMG_W(6), .IMG_H(6)) dut_c (
        .clk(clk), .rst_n(rst_n), .pix_in(pix), .pix_in_valid(vc), .sof(sofi),
        .w00(wc[0]), .w01(wc[1]), .w02(wc[2]), .w10(wc[3]), .w11(wc[4]), .w12(wc[5]),
        .w20(wc[6]), .w21(wc[7]), .w22(wc[8]), .window_valid(wvc), .frame_done(fdc));

    always_comb begin
        s_w = wa; s_wv = wva; s_fd = fda;
        other_pulse = wvb | fdb | wvc | fdc;
        if (sel == 1) begin
            s_w = wb; s_wv = wvb; s_fd = fdb;
            other_pulse = wva | fda | wvc | fdc;
        end else if (sel == 2) begin
            s_w = wc; s_wv = wvc; s_fd = fdc;
            other_pulse = wva | fda | wvb | fdb;
        end
    end

    typedef struct packed {
        logic [31:0]     cyc;
        logic            wv;
        logic            fd;
        logic [8:0][7:0] w;
    } exp_t;

    typedef struct packed {
        logic [7:0]      idx;
        logic            fd;
        logic [8:0][7:0] w;
    } vec_t;

    exp_t q[$];
    vec_t tbl[4];
    int   nchecks = 0, nerr = 0, win_cnt = 0, fd_cnt = 0;
    int   m_row = 0, m_col = 0, img_w = 4, img_h = 4;
    int   img[6][6];
    bit   use_model = 1'b0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [8:0][7:0] mkw(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        logic [8:0][7:0] r;
        r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2);
        r[3] = 8'(a3); r[4] = 8'(a4); r[5] = 8'(a5);
        r[6] = 8'(a6); r[7] = 8'(a7); r[8] = 8'(a8);
        return r;
    endfunction

    // Reference model: tracks position and stores the image by (row, col).
    task automatic model_accept(input int p, input bit s);
        exp_t e;
        bit   emit, fd;
        if (s) begin m_row = 0; m_col = 0; end
        img[m_row][m_col] = p;
        emit = (m_row >= 2) && (m_col >= 2);
`ifdef WINDOW_STRIDE2_EN
        emit = emit && (m_row % 2 == 0) && (m_col % 2 == 0);
`endif
        fd = (m_row == img_h - 1) && (m_col == img_w - 1);
        if (use_model && (emit || fd)) begin
            e.cyc = 32'(cyc + 1); e.wv = emit; e.fd = fd; e.w = '0;
            if (emit)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e.w[r*3+c] = 8'(img[m_row-2+r][m_col-2+c]);
            q.push_back(e);
        end
        if (m_col == img_w - 1) begin
            m_col = 0;
            m_row = (m_row == img_h - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    task automatic drive(input int p, input bit v, input bit s);
        @(negedge clk);
        pix = 8'(p); valid = v; sofi = s;
        if (v) model_accept(p, s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0; sofi = 1'b0;
        end
    endtask

    task automatic set_frame(input int s, input int w, input int h);
        sel = s; img_w = w; img_h = h; m_row = 0; m_col = 0;
        win_cnt = 0; fd_cnt = 0;
    endtask

    task automatic mon_step();
        exp_t e;
        if (!rst_n) return;
        while (q.size() > 0 && int'(q[0].cyc) < cyc) begin
            e = q.pop_front();
            chk("missing_pulse", 72'(cyc), 72'(e.cyc));
        end
        if (other_pulse) chk("idle_instance_pulse", 72'(other_pulse), 72'(0));
        if (s_wv || s_fd) begin
            if (s_wv) win_cnt++;
            if (s_fd) fd_cnt++;
            if (q.size() > 0 && int'(q[0].cyc) == cyc) begin
                e = q.pop_front();
                chk("window_valid", 72'(s_wv), 72'(e.wv));
                chk("frame_done", 72'(s_fd), 72'(e.fd));
                if (e.wv) chk("window", s_w, e.w);
            end else begin
                chk("unexpected_pulse", {70'(0), s_wv, s_fd}, 72'(0));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_w"}, s_w, 72'(0));
        chk({tag, "_valid"}, 72'(s_wv), 72'(0));
        chk({tag, "_done"}, 72'(s_fd), 72'(0));
    endtask

    initial begin
        tbl[0] = '{idx: 8'd10, fd: 1'b0, w: mkw(0, 1, 2, 4, 5, 6, 8, 9, 10)};
        tbl[1] = '{idx: 8'd11, fd: 1'b0, w: mkw(1, 2, 3, 5, 6, 7, 9, 10, 11)};
        tbl[2] = '{idx: 8'd14, fd: 1'b0, w: mkw(4, 5, 6, 8, 9, 10, 12, 13, 14)};
        tbl[3] = '{idx: 8'd15, fd: 1'b1, w: mkw(5, 6, 7, 9, 10, 11, 13, 14, 15)};

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (2) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;

        // 4x4 raster 0..15 against the hand-computed table.
        set_frame(0, 4, 4);
        use_model = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(i, 1'b1, i == 0);
            for (int k = 0; k < 4; k++)
                if (int'(tbl[k].idx) == i)
                    q.push_back('{cyc: 32'(cyc + 1), wv: 1'b1, fd: tbl[k].fd, w: tbl[k].w});
        end
        idle(4);
        chk("t1_window_count", 72'(win_cnt), 72'(4));
        chk("t1_done_count", 72'(fd_cnt), 72'(1));
        use_model = 1'b1;

        // Same frame with a bubble after every pixel.
        set_frame(0, 4, 4);
        for (int i = 0; i < 16; i++) begin
            drive(i, 1'b1, i == 0);
            drive(0, 1'b0, 1'b0);
        end
        idle(4);
        chk("t2_window_count", 72'(win_cnt), 72'(4));

        // Back-to-back frames, second without sof.
        set_frame(0, 4, 4);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++)
                drive(f * 100 + i, 1'b1, (f == 0) && (i == 0));
        idle(4);
        chk("t3_window_count", 72'(win_cnt), 72'(8));
        chk("t3_done_count", 72'(fd_cnt), 72'(2));

        // 5x5: sof re-asserted at pixel 6 aborts the first frame.
        set_frame(1, 5, 5);
        for (int i = 0; i < 6; i++) drive(i, 1'b1, i == 0);
        for (int i = 0; i < 25; i++) drive(50 + i, 1'b1, i == 0);
        idle(4);
        chk("t4_window_count", 72'(win_cnt), 72'(9));
        chk("t4_done_count", 72'(fd_cnt), 72'(1));

        // Mid-frame reset, then a full frame with no sof.
        set_frame(0, 4, 4);
        for (int i = 0; i < 13; i++) drive(i, 1'b1, i == 0);
        idle(3);
        @(negedge clk);
        rst_n = 1'b0; valid = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        rst_n = 1'b1;
        set_frame(0, 4, 4);
        for (int i = 0; i < 16; i++) drive(200 + i, 1'b1, 1'b0);
        idle(4);
        chk("t5_window_count", 72'(win_cnt), 72'(4));
        chk("t5_done_count", 72'(fd_cnt), 72'(1));

        // 6x6 raster 0..35: stride-dependent window count.
        set_frame(2, 6, 6);
        for (int i = 0; i < 36; i++) drive(i, 1'b1, i == 0);
        idle(4);
`ifdef WINDOW_STRIDE2_EN
        chk("t6_window_count", 72'(win_cnt), 72'(4));
`else
        chk("t6_window_count", 72'(win_cnt), 72'(16));
`endif
        chk("t6_done_count", 72'(fd_cnt), 72'(1));
        chk("scoreboard_drained", 72'(q.size()), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 sliding-window generator that sits directly upstream of the 3x3 convolution MAC. It accepts an 8-bit unsigned raster-scan pixel stream, one pixel per cycle, and buffers two image lines internally. For each pixel that completes a full 3x3 neighbourhood, it presents the nine window pixels with a one-cycle valid pulse. The window outputs drive the MAC's `w00..w22` / `pixel_valid` inputs directly. There is no padding, so the output grid is (IMG_W-2) x (IMG_H-2).

## Interface
- `IMG_W`, default 28: pixels per line; legal range >= 3.
- `IMG_H`, default 28: lines per frame; legal range >= 3.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `pix_in` input, 8 bits: unsigned pixel.
- `pix_in_valid` input, 1 bit: `pix_in` is accepted this cycle.
- `sof` input, 1 bit: start of frame. It qualifies only when `pix_in_valid`=1, and marks that pixel as (row 0, col 0).
- `w00..w22` output, 8 bits each: window pixels. `wRC` is row R (0 = oldest line), column C (0 = leftmost).
- `window_valid` output, 1 bit: one-cycle pulse when the window outputs are a new, complete window.
- `frame_done` output, 1 bit: one-cycle pulse after the last pixel of a frame, (IMG_H-1, IMG_W-1), is accepted.

## Operation
- Column counter `col` runs 0..IMG_W-1 and row counter `row` runs 0..IMG_H-1. Both advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after IMG_H-1, so back-to-back frames are handled without `sof`.
- `sof`=1 on an accepted pixel forces that pixel to position (0,0).
  - This applies mid-frame too; the partial frame is abandoned and no `frame_done` is generated for it.
  - Stale line-buffer contents are harmless, because windows are gated by `row`.
- Two line delays hold the previous two lines. Each accepted pixel shifts a 3-column window register:
  - new column = {line-2 pixel, line-1 pixel, `pix_in`} at the current `col`.
- Window emission: when the pixel at (r,c) is accepted with r>=2 and c>=2, the emitted window covers rows r-2..r and cols c-2..c.
  - `w22` = pixel (r,c).
  - `w00` = pixel (r-2,c-2).
- Columns never mix across a line boundary. Windows with c<2 are suppressed.
- No backpressure: the downstream stage must accept every window.
- Pixels are treated as unsigned 8-bit. No arithmetic is performed.

## Timing
- Latency: the window and `window_valid` appear on the registered outputs 1 cycle after the accepting edge of the completing pixel.
- `window_valid` and `frame_done` are single-cycle pulses. `frame_done` coincides with the final `window_valid` of the frame.
- `w00..w22` hold their value between windows. They may change on non-emitting accepted pixels; they are only meaningful when `window_valid`=1.
- Bubbles (`pix_in_valid`=0) freeze all state and produce no pulses. Throughput is 1 window per cycle at full input rate.
- Reset: `rst_n`=0 at a rising edge sets the counters to 0, `w00..w22` to 0, `window_valid` to 0, and `frame_done` to 0.
  - Line-buffer contents need not be cleared.
  - Reset mid-frame discards the frame; the next accepted pixel is (0,0).
- A frame of IMG_W x IMG_H pixels yields exactly (IMG_W-2)(IMG_H-2) windows.

## Configuration
- `WINDOW_STRIDE2_EN`
  - Defined: windows are emitted only when (r-2) and (c-2) are both even. This gives stride 2 and floor((IMG_W-1)/2) x floor((IMG_H-1)/2) windows per frame.
  - `frame_done` is unchanged: it still pulses on the last pixel.
  - Undefined: stride 1, as described above.

## Structure
- Shared package `cnn_pkg` holds:
  - `PIX_W` = 8;
  - default `IMG_W` / `IMG_H` constants;
  - a pixel typedef shared with the MAC.
- Sub-module `line_delay`:
  - parameterised depth IMG_W, 8 bits wide;
  - enable-gated circular buffer with a single read/write pointer;
  - instantiated twice, cascaded.

## Test plan
- 4x4 frame, `pix_in` = 0..15 raster, continuous valid, `sof` on pixel 0:
  - exactly 4 windows;
  - first window 1 cycle after pixel 10: w00..w22 = 0,1,2,4,5,6,8,9,10;
  - last window w22=15, with `frame_done` in the same cycle.
- Same frame with `pix_in_valid` toggling 1/0: identical windows, each 1 cycle after its completing pixel; no pulses during bubbles.
- Two back-to-back 4x4 frames, with no `sof` on the second: 8 windows total. The second frame's first window uses only second-frame pixels.
- `sof` asserted at pixel 6 of a 5x5 frame, then a full 5x5 frame: no `frame_done` for the aborted frame; exactly 9 windows from the new frame.
- `rst_n` low for 1 cycle mid-frame: all outputs 0 on the next cycle. The following full 4x4 frame (no `sof`) yields 4 correct windows.
- `WINDOW_STRIDE2_EN` defined, 6x6 frame of values 0..35: exactly 4 windows, with w22 = 14, 16, 26, 28.
